vop2_operand_fetch: RTL and testbench



---
 rtl/vop2_operand_fetch.sv | 156 +++++++++++++++
 tb/tb_vop2_operand_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vop2_operand_fetch.sv
// VOP2 decode and operand-fetch stage: decodes the instruction dword, resolves SRC0 and VSRC1,
// and hands opcode, destination and both operands to the ALU over a valid/ready handshake.
module vop2_operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst_word,
  output logic [6:0]  sgpr_rd_addr,
  input  logic [31:0] sgpr_rd_data,
  output logic        vgpr_rd_en,
  output logic [7:0]  vgpr_rd_addr0,
  output logic [7:0]  vgpr_rd_addr1,
  input  logic [31:0] vgpr_rd_data0,
  input  logic [31:0] vgpr_rd_data1,
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic [5:0]  alu_op,
  output logic [7:0]  alu_vdst,
  output logic [31:0] alu_src0,
  output logic [31:0] alu_src1,
  output logic        illegal_inst,
  output logic        illegal_src
);

  typedef enum logic [2:0] {StIdle, StWaitLit, StRead, StCapture, StOut} state_e;

  state_e      state_q;
  logic [5:0]  op_q;
  logic [7:0]  vdst_q;
  logic [7:0]  vsrc1_q;
  logic [8:0]  src0_q;
  logic [31:0] lit_q;
  logic [31:0] src0_val_q;

  logic [8:0]  in_src0;
  logic        in_reserved;
  logic [31:0] src0_res;

  assign in_src0    = inst_word[8:0];
  assign inst_ready = !rst && (state_q == StIdle || state_q == StWaitLit);

  always_comb begin
    in_reserved = ((in_src0 >= 9'd106) && (in_src0 <= 9'd127)) ||
                  ((in_src0 >= 9'd209) && (in_src0 <= 9'd239)) ||
                  ((in_src0 >= 9'd248) && (in_src0 <= 9'd254));
  end

  // Non-VGPR SRC0 resolution; reserved codes and VGPR codes fall through to zero here.
  always_comb begin
    src0_res = '0;
    if (src0_q[8]) begin
      src0_res = '0;
    end else if (src0_q <= 9'd105) begin
      src0_res = sgpr_rd_data;
    end else if ((src0_q >= 9'd129) && (src0_q <= 9'd192)) begin
      src0_res = {23'd0, src0_q} - 32'd128;
    end else if ((src0_q >= 9'd193) && (src0_q <= 9'd208)) begin
      src0_res = 32'd192 - {23'd0, src0_q};
    end else if ((src0_q >= 9'd240) && (src0_q <= 9'd247)) begin
      unique case (src0_q[2:0])
        3'd0: src0_res = 32'h3F00_0000;
        3'd1: src0_res = 32'hBF00_0000;
        3'd2: src0_res = 32'h3F80_0000;
        3'd3: src0_res = 32'hBF80_0000;
        3'd4: src0_res = 32'h4000_0000;
        3'd5: src0_res = 32'hC000_0000;
        3'd6: src0_res = 32'h4080_0000;
        3'd7: src0_res = 32'hC080_0000;
      endcase
    end else if (src0_q == 9'd255) begin
      src0_res = lit_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= '0;
      vdst_q        <= '0;
      vsrc1_q       <= '0;
      src0_q        <= '0;
      lit_q         <= '0;
      src0_val_q    <= '0;
      sgpr_rd_addr  <= '0;
      vgpr_rd_en    <= 1'b0;
      vgpr_rd_addr0 <= '0;
      vgpr_rd_addr1 <= '0;
      alu_valid     <= 1'b0;
      alu_op        <= '0;
      alu_vdst      <= '0;
      alu_src0      <= '0;
      alu_src1      <= '0;
      illegal_inst  <= 1'b0;
      illegal_src   <= 1'b0;
    end else begin
      illegal_inst <= 1'b0;
      illegal_src  <= 1'b0;
      vgpr_rd_en   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (inst_valid) begin
            op_q    <= inst_word[30:25];
            vdst_q  <= inst_word[24:17];
            vsrc1_q <= inst_word[16:9];
            src0_q  <= in_src0;
            if (inst_word[31]) begin
              illegal_inst <= 1'b1;
            end else begin
              illegal_src <= in_reserved;
              if (in_src0 == 9'd255) begin
                state_q <= StWaitLit;
              end else begin
                state_q       <= StRead;
                vgpr_rd_en    <= 1'b1;
                vgpr_rd_addr0 <= inst_word[7:0];
                vgpr_rd_addr1 <= inst_word[16:9];
                sgpr_rd_addr  <= inst_word[6:0];
              end
            end
          end
        end
        StWaitLit: begin
          if (inst_valid) begin
            lit_q         <= inst_word;
            state_q       <= StRead;
            vgpr_rd_en    <= 1'b1;
            vgpr_rd_addr0 <= src0_q[7:0];
            vgpr_rd_addr1 <= vsrc1_q;
            sgpr_rd_addr  <= src0_q[6:0];
          end
        end
        StRead: begin
          src0_val_q <= src0_res;
          state_q    <= StCapture;
        end
        StCapture: begin
          alu_src1  <= vgpr_rd_data1;
          alu_src0  <= src0_q[8] ? vgpr_rd_data0 : src0_val_q;
          alu_op    <= op_q;
          alu_vdst  <= vdst_q;
          alu_valid <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          if (alu_ready) begin
            alu_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vop2_operand_fetch.sv
// Randomized bench for vop2_operand_fetch: register-file models, a rule-based SRC0 reference and
// cycle-accurate latency, backpressure and reset checks.
module tb_vop2_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [6:0]  sgpr_rd_addr;
  logic [31:0] sgpr_rd_data;
  logic        vgpr_rd_en;
  logic [7:0]  vgpr_rd_addr0;
  logic [7:0]  vgpr_rd_addr1;
  logic [31:0] vgpr_rd_data0;
  logic [31:0] vgpr_rd_data1;
  logic        alu_valid;
  logic        alu_ready;
  logic [5:0]  alu_op;
  logic [7:0]  alu_vdst;
  logic [31:0] alu_src0;
  logic [31:0] alu_src1;
  logic        illegal_inst;
  logic        illegal_src;

  int errors = 0;
  int checks = 0;

  logic [31:0] sgpr_mem [128];
  logic [31:0] vgpr_mem [256];
  logic [31:0] fconst   [8] = '{32'h3F000000, 32'hBF000000, 32'h3F800000, 32'hBF800000,
                                32'h40000000, 32'hC0000000, 32'h40800000, 32'hC0800000};
  logic [8:0]  edge_codes [14] = '{9'd0, 9'd105, 9'd106, 9'd127, 9'd128, 9'd129, 9'd192,
                                   9'd193, 9'd208, 9'd209, 9'd239, 9'd240, 9'd247, 9'd248};

  always #5 clk = ~clk;

  assign sgpr_rd_data = sgpr_mem[sgpr_rd_addr];

  always @(posedge clk) begin
    if (vgpr_rd_en) begin
      vgpr_rd_data0 <= vgpr_mem[vgpr_rd_addr0];
      vgpr_rd_data1 <= vgpr_mem[vgpr_rd_addr1];
    end
  end

  vop2_operand_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_word     (inst_word),
    .sgpr_rd_addr  (sgpr_rd_addr),
    .sgpr_rd_data  (sgpr_rd_data),
    .vgpr_rd_en    (vgpr_rd_en),
    .vgpr_rd_addr0 (vgpr_rd_addr0),
    .vgpr_rd_addr1 (vgpr_rd_addr1),
    .vgpr_rd_data0 (vgpr_rd_data0),
    .vgpr_rd_data1 (vgpr_rd_data1),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_op        (alu_op),
    .alu_vdst      (alu_vdst),
    .alu_src0      (alu_src0),
    .alu_src1      (alu_src1),
    .illegal_inst  (illegal_inst),
    .illegal_src   (illegal_src)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_reserved(input int s);
    return (s >= 106 && s <= 127) || (s >= 209 && s <= 239) || (s >= 248 && s <= 254);
  endfunction

  function automatic logic [31:0] ref_src0(input int s, input logic [31:0] lit);
    int v;
    if (s <= 105) return sgpr_mem[s];
    if (s >= 129 && s <= 192) return 32'(s - 128);
    if (s >= 193 && s <= 208) begin
      v = 192 - s;
      return 32'(v);
    end
    if (s >= 240 && s <= 247) return fconst[s - 240];
    if (s == 255) return lit;
    if (s >= 256) return vgpr_mem[s - 256];
    return 32'd0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_ready"}, 32'(inst_ready), 0);
    check({tag, "_alu_valid"}, 32'(alu_valid), 0);
    check({tag, "_rd_en"}, 32'(vgpr_rd_en), 0);
    check({tag, "_addrs"}, {9'd0, sgpr_rd_addr, vgpr_rd_addr0, vgpr_rd_addr1}, 0);
    check({tag, "_op_vdst"}, {18'd0, alu_op, alu_vdst}, 0);
    check({tag, "_src0"}, alu_src0, 0);
    check({tag, "_src1"}, alu_src1, 0);
    check({tag, "_pulses"}, {30'd0, illegal_inst, illegal_src}, 0);
  endtask

  // Issues one instruction (plus literal after `gap` idle cycles) and checks it end to end,
  // holding alu_ready low for `stall` cycles of OUT.
  task automatic run_inst(input logic [31:0] w, input logic [31:0] lit, input int gap,
                          input int stall);
    int t;
    int s0;
    logic [31:0] e0;
    logic [31:0] e1;
    s0 = int'(w[8:0]);
    check("ready_idle", 32'(inst_ready), 1);
    inst_valid = 1'b1;
    inst_word  = w;
    @(negedge clk);
    t = 1;
    inst_valid = 1'b0;
    inst_word  = $urandom;
    if (w[31]) begin
      check("illegal_inst", 32'(illegal_inst), 1);
      check("illegal_no_valid", 32'(alu_valid), 0);
      check("illegal_ready", 32'(inst_ready), 1);
      return;
    end
    check("illegal_src", 32'(illegal_src), 32'(is_reserved(s0)));
    check("illegal_inst_quiet", 32'(illegal_inst), 0);
    if (s0 == 255) begin
      check("ready_wait_lit", 32'(inst_ready), 1);
      repeat (gap) begin
        @(negedge clk);
        t++;
      end
      inst_valid = 1'b1;
      inst_word  = lit;
      @(negedge clk);
      t++;
      inst_valid = 1'b0;
    end else begin
      check("ready_busy", 32'(inst_ready), 0);
    end
    check("rd_en", 32'(vgpr_rd_en), 1);
    check("rd_addr0", 32'(vgpr_rd_addr0), 32'(w[7:0]));
    check("rd_addr1", 32'(vgpr_rd_addr1), 32'(w[16:9]));
    check("sgpr_addr", 32'(sgpr_rd_addr), 32'(w[6:0]));
    e0 = ref_src0(s0, lit);
    e1 = vgpr_mem[w[16:9]];
    while (!alu_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("latency", 32'(t), (s0 == 255) ? 32'(4 + gap) : 32'd3);
    for (int i = 0; i <= stall; i++) begin
      check("out_valid", 32'(alu_valid), 1);
      check("out_op", 32'(alu_op), 32'(w[30:25]));
      check("out_vdst", 32'(alu_vdst), 32'(w[24:17]));
      check("out_src0", alu_src0, e0);
      check("out_src1", alu_src1, e1);
      check("out_no_ready", 32'(inst_ready), 0);
      if (i == stall) alu_ready = 1'b1;
      @(negedge clk);
    end
    alu_ready = 1'b0;
    check("valid_drop", 32'(alu_valid), 0);
    check("ready_next", 32'(inst_ready), 1);
  endtask

  initial begin
    logic [31:0] w;
    logic [8:0]  s0;
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst_word  = '0;
    alu_ready  = 1'b0;
    for (int i = 0; i < 256; i++) vgpr_mem[i] = $urandom;
    for (int i = 0; i < 128; i++) sgpr_mem[i] = $urandom;
    vgpr_mem[2]  = 32'h11111111;
    vgpr_mem[7]  = 32'h22222222;
    sgpr_mem[10] = 32'hCAFEF00D;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(inst_ready), 1);

    run_inst(32'h060A0F02, 32'h0, 0, 0);
    run_inst(32'h060200FF, 32'h12345678, 0, 0);
    run_inst(32'h060200FF, 32'h9ABCDEF0, 3, 0);
    foreach (edge_codes[i]) run_inst({1'b0, 6'd9, 8'd33, 8'd7, edge_codes[i]}, 32'h0, 0, 0);
    run_inst({1'b0, 6'd9, 8'd33, 8'd7, 9'd242}, 32'h0, 0, 0);
    run_inst({1'b0, 6'd1, 8'd2, 8'd3, 9'd10}, 32'h0, 0, 0);
    run_inst(32'h060A0F02, 32'h0, 0, 5);
    run_inst(32'h80000000, 32'h0, 0, 0);
    run_inst({1'b0, 6'd4, 8'd5, 8'd6, 9'd110}, 32'h0, 0, 0);

    // Reset while waiting for the literal; the next dword must decode as an instruction.
    inst_valid = 1'b1;
    inst_word  = 32'h060200FF;
    @(negedge clk);
    inst_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait_lit");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_release1", 32'(inst_ready), 1);
    run_inst(32'h060A0F02, 32'h0, 0, 0);

    // Reset while the bundle is being offered.
    inst_valid = 1'b1;
    inst_word  = 32'h060A0F02;
    @(negedge clk);
    inst_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_valid", 32'(alu_valid), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_out");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_release2", 32'(inst_ready), 1);
    run_inst(32'h060A0F02, 32'h0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       s0 = 9'($urandom);
        1:       s0 = edge_codes[$urandom_range(0, 13)];
        2:       s0 = 9'd255;
        default: s0 = 9'(256 + $urandom_range(0, 255));
      endcase
      w = {1'b0, 6'($urandom), 8'($urandom), 8'($urandom), s0};
      if ($urandom_range(0, 9) == 0) w[31] = 1'b1;
      run_inst(w, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
